// File: rtl/multicycle_adder_if.sv
// Handshake and operand/result bundle for multicycle_adder.
// The master side offers operands and consumes results.
// The slave side is the adder itself.
interface multicycle_adder_if #(
  parameter int WIDTH = 16
) ();

  // Input handshake and operands
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;

  // Output handshake and result
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output c_in,
    output sub,
    input  out_valid,
    output out_ready,
    input  sum,
    input  c_out,
    input  ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  c_in,
    input  sub,
    output out_valid,
    input  out_ready,
    output sum,
    output c_out,
    output ovf
  );

endinterface

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor.
// Adds two WIDTH-bit operands CHUNK bits per clock, least significant chunk
// first, with the carry held in a register between chunks. Subtraction is
// done as a + ~b + ~borrow_in, so the same chunk adder serves both. One
// operation is in flight at a time; results are held until consumed.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_adder_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Counter only needs to reach NCHUNK-1; keep at least one bit.
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;

  // Operands captured at acceptance (B already conditionally inverted)
  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;

  logic [WIDTH-1:0]  sum_q;
  logic              c_out_q;
  logic              ovf_q;

  logic              accept;
  logic              release_res;
  logic              last_chunk;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_res;
  logic              carry_into_msb;

  // One chunk of ripple addition: {carry_out, sum} = x + y + ci.
  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Carry entering the top bit of a chunk, recovered from its sum bit.
  function automatic logic msb_carry_in(
    input logic x_msb,
    input logic y_msb,
    input logic s_msb
  );
    return x_msb ^ y_msb ^ s_msb;
  endfunction

  assign accept      = (state_q == IDLE) && bus.in_valid;
  assign release_res = (state_q == DONE) && bus.out_ready;
  assign last_chunk  = (cnt_q == LAST_CHUNK);

  // Handshake outputs come straight from the state register; in_ready is
  // additionally held low while reset is asserted.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ADD;
        end
      end
      ADD: begin
        if (last_chunk) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (release_res) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select the current chunk of each operand and add it with the carry
  always_comb begin
    a_chunk        = a_p0[cnt_q*CHUNK +: CHUNK];
    b_chunk        = b_p0[cnt_q*CHUNK +: CHUNK];
    chunk_res      = chunk_add(a_chunk, b_chunk, carry_q);
    carry_into_msb = msb_carry_in(a_chunk[CHUNK-1], b_chunk[CHUNK-1],
                                  chunk_res[CHUNK-1]);
  end

  // ---- stage p0: operand capture on acceptance ----
  // Capture operands on acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= bus.a;
      b_p0 <= bus.b ^ {WIDTH{bus.sub}};
    end
  end

  // ---- stage p1: chunk-serial accumulation into the result ----
  // Chunk counter, carry chain and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            carry_q <= bus.c_in ^ bus.sub;
          end
        end
        ADD: begin
          sum_q[cnt_q*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
          carry_q                     <= chunk_res[CHUNK];
          if (last_chunk) begin
            cnt_q   <= '0;
            c_out_q <= chunk_res[CHUNK];
            ovf_q   <= carry_into_msb ^ chunk_res[CHUNK];
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          // DONE: everything held until the result is taken
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Testbench for multicycle_adder: directed vectors on a 16/4 instance,
// random add/subtract runs on 16/16 and 8/1 instances.
module tb_multicycle_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(16)) if0 ();
  multicycle_adder_if #(.WIDTH(16)) if1 ();
  multicycle_adder_if #(.WIDTH(8))  if2 ();

  multicycle_adder #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  multicycle_adder #(.WIDTH(8),  .CHUNK(1))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {ovf, c_out, sum[15:0]} for a w-bit operation.
  function automatic logic [17:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci,
                                        input logic s);
    logic [31:0] mask, bb, full, sm;
    logic        co, ov;
    mask = (32'd1 << w) - 32'd1;
    bb   = (s ? ~b : b) & mask;
    full = (a & mask) + bb + {31'd0, ci ^ s};
    sm   = full & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
    return {ov, co, sm[15:0]};
  endfunction

  task automatic accept0(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s);
    check("acc_in_ready", {31'd0, if0.in_ready}, 32'd1);
    if0.a = a; if0.b = b; if0.c_in = ci; if0.sub = s; if0.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    check("acc_in_ready_low", {31'd0, if0.in_ready}, 32'd0);
  endtask

  task automatic wait0(input int exp_lat);
    int n;
    bit ir_hi;
    n = 0; ir_hi = 1'b0;
    while (!if0.out_valid && n < 40) begin
      if (if0.in_ready) ir_hi = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
    check("in_ready_busy", {31'd0, ir_hi}, 32'd0);
  endtask

  task automatic result0(input string tag, input logic [15:0] es,
                         input logic ec, input logic eo);
    check({tag, "_sum"},   {16'd0, if0.sum},   {16'd0, es});
    check({tag, "_c_out"}, {31'd0, if0.c_out}, {31'd0, ec});
    check({tag, "_ovf"},   {31'd0, if0.ovf},   {31'd0, eo});
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
    check({tag, "_vld_clr"}, {31'd0, if0.out_valid}, 32'd0);
    check({tag, "_rdy_set"}, {31'd0, if0.in_ready},  32'd1);
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic s);
    logic [17:0] e;
    int n;
    e = model(16, {16'd0, a}, {16'd0, b}, ci, s);
    if1.a = a; if1.b = b; if1.c_in = ci; if1.sub = s; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    n = 0;
    while (!if1.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("r16_lat",   n, 1);
    check("r16_sum",   {16'd0, if1.sum},   {16'd0, e[15:0]});
    check("r16_c_out", {31'd0, if1.c_out}, {31'd0, e[16]});
    check("r16_ovf",   {31'd0, if1.ovf},   {31'd0, e[17]});
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic s);
    logic [17:0] e;
    int n;
    e = model(8, {24'd0, a}, {24'd0, b}, ci, s);
    if2.a = a; if2.b = b; if2.c_in = ci; if2.sub = s; if2.in_valid = 1'b1;
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    n = 0;
    while (!if2.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("r8_lat",   n, 8);
    check("r8_sum",   {24'd0, if2.sum},   {24'd0, e[7:0]});
    check("r8_c_out", {31'd0, if2.c_out}, {31'd0, e[16]});
    check("r8_ovf",   {31'd0, if2.ovf},   {31'd0, e[17]});
    if2.out_ready = 1'b1;
    @(posedge clk); #1;
    if2.out_ready = 1'b0;
  endtask

  initial begin
    if0.in_valid = 0; if0.a = '0; if0.b = '0; if0.c_in = 0; if0.sub = 0; if0.out_ready = 0;
    if1.in_valid = 0; if1.a = '0; if1.b = '0; if1.c_in = 0; if1.sub = 0; if1.out_ready = 0;
    if2.in_valid = 0; if2.a = '0; if2.b = '0; if2.c_in = 0; if2.sub = 0; if2.out_ready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, if0.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    check("rst_sum",       {16'd0, if0.sum},       32'd0);
    check("rst_c_out",     {31'd0, if0.c_out},     32'd0);
    check("rst_ovf",       {31'd0, if0.ovf},       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);

    // Basic add with carry-in
    accept0(16'h1234, 16'h0FCD, 1'b1, 1'b0);
    wait0(4);
    result0("add_basic", 16'h2202, 1'b0, 1'b0);

    // Full ripple and signed overflow
    accept0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait0(4);
    result0("ripple", 16'h0000, 1'b1, 1'b0);
    accept0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait0(4);
    result0("add_ovf", 16'h8000, 1'b0, 1'b1);

    // Subtracts
    accept0(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait0(4);
    result0("sub_neg", 16'hFFFE, 1'b0, 1'b0);
    accept0(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait0(4);
    result0("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    accept0(16'h0010, 16'h0004, 1'b1, 1'b1);
    wait0(4);
    result0("sub_borrow", 16'h000B, 1'b1, 1'b0);

    // Backpressure: held DONE while inputs wiggle
    accept0(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait0(4);
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = ~if0.in_valid;
      if0.a = 16'($urandom); if0.b = 16'($urandom);
      if0.c_in = ~if0.c_in; if0.sub = ~if0.sub;
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, if0.out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, if0.in_ready},  32'd0);
      check("bp_sum",       {16'd0, if0.sum},       32'h1010);
      check("bp_c_out",     {31'd0, if0.c_out},     32'd0);
      check("bp_ovf",       {31'd0, if0.ovf},       32'd0);
    end
    if0.in_valid = 1'b0;
    result0("bp_release", 16'h1010, 1'b0, 1'b0);
    // Back-to-back operation right after the release
    accept0(16'h4000, 16'h4000, 1'b0, 1'b0);
    wait0(4);
    result0("b2b", 16'h8000, 1'b0, 1'b1);

    // Reset in the middle of chunk 2
    accept0(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    check("mid_rst_sum",       {16'd0, if0.sum},       32'd0);
    check("mid_rst_c_out",     {31'd0, if0.c_out},     32'd0);
    check("mid_rst_ovf",       {31'd0, if0.ovf},       32'd0);
    check("mid_rst_in_ready",  {31'd0, if0.in_ready},  32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_valid", {31'd0, if0.out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rel_ready", {31'd0, if0.in_ready}, 32'd1);
    accept0(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait0(4);
    result0("after_rst", 16'h0100, 1'b0, 1'b0);

    // Random ops on single-chunk and bit-serial configurations
    for (int i = 0; i < 200; i++) begin
      op1(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      op2(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
